// File: rtl/pwm_duty_ramp_pkg.sv
// Shared types and constants for the PWM duty ramp block.
package pwm_pkg;
  localparam int DUTY_W           = 8;
  localparam int DEFAULT_PRESCALE = 1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_t;
endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Control/status bundle between the SPI register side and the duty ramp.
// Handshake: none; all fields are level signals, sampled on every rising clk edge.
interface pwm_duty_ramp_if #(
  parameter int RATE_W = 8
);
  import pwm_pkg::*;

  logic              ramp_en;
  logic [DUTY_W-1:0] target_duty;
  logic [RATE_W-1:0] rate_div;
  logic [DUTY_W-1:0] duty_out;
  logic              busy;
  logic              done;
  ramp_state_t       state;

  modport master (
    output ramp_en, target_duty, rate_div,
    input  duty_out, busy, done, state
  );

  modport slave (
    input  ramp_en, target_duty, rate_div,
    output duty_out, busy, done, state
  );
endinterface

// File: rtl/pwm_duty_ramp_tick_prescaler.sv
// Free-running base-tick divider that only counts while run is high.
module tick_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/pwm_duty_ramp.sv
// Slews duty_out toward target_duty in STEP increments at a programmable rate,
// or passes the target straight through when ramping is disabled.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int STEP     = 1,
  parameter int RATE_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_duty_ramp_if.slave  bus
);
  ramp_state_t       state_q;
  logic [DUTY_W-1:0] duty_q;
  logic              busy_q;
  logic              done_q;
  logic [RATE_W-1:0] rate_cnt;
  logic              tick;
  logic              step_evt;
  logic [RATE_W-1:0] rate_max;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   dn_diff;
  logic [DUTY_W-1:0] up_val;
  logic [DUTY_W-1:0] dn_val;
  logic [DUTY_W-1:0] step_val;
  logic [DUTY_W-1:0] target;

  assign target = bus.target_duty;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (bus.ramp_en && (state_q != IDLE)),
    .tick  (tick)
  );

  assign rate_max = (bus.rate_div == '0) ? RATE_W'(1) : bus.rate_div;
  assign step_evt = tick && (rate_cnt == rate_max - RATE_W'(1));

  // Extra MSB catches carry/borrow so the step saturates at the target instead of wrapping.
  assign up_sum   = {1'b0, duty_q} + (DUTY_W+1)'(STEP);
  assign dn_diff  = {1'b0, duty_q} - (DUTY_W+1)'(STEP);
  assign up_val   = (up_sum > {1'b0, target}) ? target : up_sum[DUTY_W-1:0];
  assign dn_val   = (dn_diff[DUTY_W] || dn_diff[DUTY_W-1:0] < target) ? target : dn_diff[DUTY_W-1:0];
  assign step_val = (target > duty_q) ? up_val : dn_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rate_cnt <= '0;
    end else if (!bus.ramp_en) begin
      state_q  <= IDLE;
      duty_q   <= target;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rate_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q   <= 1'b0;
          rate_cnt <= '0;
          if (target > duty_q) begin
            state_q <= UP;
            busy_q  <= 1'b1;
          end else if (target < duty_q) begin
            state_q <= DOWN;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          if (target == duty_q) begin
            // Target moved onto the current duty between step events.
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            rate_cnt <= '0;
          end else begin
            done_q <= 1'b0;
            if (step_evt) begin
              rate_cnt <= '0;
            end else if (tick) begin
              rate_cnt <= rate_cnt + RATE_W'(1);
            end
            if (step_evt) begin
              duty_q <= step_val;
              if (step_val == target) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= (step_val < target) ? UP : DOWN;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.duty_out = duty_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: reset, bypass, ramp, saturation, reversal, abort.
module tb_pwm_duty_ramp;
  import pwm_pkg::*;

  localparam int PS = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_duty_ramp_if #(.RATE_W(8)) a_if ();
  pwm_duty_ramp_if #(.RATE_W(8)) s_if ();

  pwm_duty_ramp #(.PRESCALE(PS), .STEP(1), .RATE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  pwm_duty_ramp #(.PRESCALE(PS), .STEP(16), .RATE_W(8)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int done_a      = 0;
  int done_s      = 0;
  int busy_a      = 0;

  // event counters sampled between the active edge and the stimulus edge
  always @(posedge clk) begin
    #2;
    if (a_if.done === 1'b1) done_a++;
    if (s_if.done === 1'b1) done_s++;
    if (a_if.busy === 1'b1) busy_a++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks (called at negedge)
  task automatic drive_a(input logic en, input logic [7:0] tgt, input logic [7:0] rate);
    a_if.ramp_en     = en;
    a_if.target_duty = tgt;
    a_if.rate_div    = rate;
  endtask

  task automatic drive_s(input logic en, input logic [7:0] tgt, input logic [7:0] rate);
    s_if.ramp_en     = en;
    s_if.target_duty = tgt;
    s_if.rate_div    = rate;
  endtask

  task automatic wait_change(input logic [7:0] prev, output logic [7:0] nv);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a_if.duty_out == prev && n < 20);
    nv = a_if.duty_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int b0;
    int found;
    logic [7:0] nv;

    drive_a(1'b0, 8'h00, 8'd1);
    drive_s(1'b0, 8'h00, 8'd1);
    repeat (2) @(negedge clk);
    check("rst_duty", 32'(a_if.duty_out), 32'h00);
    check("rst_busy", 32'(a_if.busy), 32'd0);
    check("rst_done", 32'(a_if.done), 32'd0);
    check("rst_state", 32'(a_if.state), 32'(IDLE));
    rst_n = 1'b1;

    // bypass
    @(negedge clk);
    b0 = busy_a;
    drive_a(1'b0, 8'hA5, 8'd1);
    check("byp_before_edge", 32'(a_if.duty_out), 32'h00);
    @(negedge clk);
    check("byp_duty", 32'(a_if.duty_out), 32'hA5);
    repeat (3) @(negedge clk);
    check("byp_busy_never", 32'(busy_a - b0), 32'd0);

    // ramp up 0 -> 5, rate_div=2: one step every 8 cycles
    drive_a(1'b0, 8'h00, 8'd2);
    @(negedge clk);
    d0 = done_a;
    drive_a(1'b1, 8'h05, 8'd2);
    @(negedge clk);
    check("up_busy_entry", 32'(a_if.busy), 32'd1);
    check("up_state_entry", 32'(a_if.state), 32'(UP));
    for (int k = 1; k <= 5; k++) begin
      repeat (7) @(negedge clk);
      check($sformatf("up_hold_%0d", k), 32'(a_if.duty_out), 32'(k - 1));
      @(negedge clk);
      check($sformatf("up_step_%0d", k), 32'(a_if.duty_out), 32'(k));
    end
    check("up_busy_end", 32'(a_if.busy), 32'd0);
    check("up_done_pulse", 32'(a_if.done), 32'd1);
    check("up_state_end", 32'(a_if.state), 32'(IDLE));
    @(negedge clk);
    check("up_done_clear", 32'(a_if.done), 32'd0);
    check("up_done_count", 32'(done_a - d0), 32'd1);

    // saturation with STEP=16
    drive_s(1'b0, 8'hF8, 8'd1);
    @(negedge clk);
    drive_s(1'b1, 8'hFF, 8'd1);
    @(negedge clk);
    check("sat_up_busy", 32'(s_if.busy), 32'd1);
    repeat (3) @(negedge clk);
    check("sat_up_hold", 32'(s_if.duty_out), 32'hF8);
    @(negedge clk);
    check("sat_up_duty", 32'(s_if.duty_out), 32'hFF);
    check("sat_up_done", 32'(s_if.done), 32'd1);
    drive_s(1'b0, 8'h08, 8'd1);
    @(negedge clk);
    drive_s(1'b1, 8'h00, 8'd1);
    @(negedge clk);
    check("sat_dn_state", 32'(s_if.state), 32'(DOWN));
    repeat (4) @(negedge clk);
    check("sat_dn_duty", 32'(s_if.duty_out), 32'h00);
    check("sat_dn_idle", 32'(s_if.state), 32'(IDLE));
    check("sat_done_count", 32'(done_s), 32'd2);

    // mid-ramp reversal
    drive_a(1'b0, 8'h10, 8'd1);
    @(negedge clk);
    drive_a(1'b1, 8'h40, 8'd1);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (a_if.duty_out == 8'h15) found = 1;
    end
    check("rev_reach_15", 32'(found), 32'd1);
    a_if.target_duty = 8'h12;
    wait_change(8'h15, nv);
    check("rev_step_14", 32'(nv), 32'h14);
    check("rev_state_down", 32'(a_if.state), 32'(DOWN));
    wait_change(8'h14, nv);
    check("rev_step_13", 32'(nv), 32'h13);
    wait_change(8'h13, nv);
    check("rev_step_12", 32'(nv), 32'h12);
    check("rev_done", 32'(a_if.done), 32'd1);

    // abort mid-ramp
    drive_a(1'b0, 8'h20, 8'd2);
    @(negedge clk);
    drive_a(1'b1, 8'h80, 8'd2);
    @(negedge clk);
    check("abort_busy_pre", 32'(a_if.busy), 32'd1);
    d0 = done_a;
    @(negedge clk);
    a_if.ramp_en = 1'b0;
    @(negedge clk);
    check("abort_duty", 32'(a_if.duty_out), 32'h80);
    check("abort_busy", 32'(a_if.busy), 32'd0);
    check("abort_state", 32'(a_if.state), 32'(IDLE));
    repeat (2) @(negedge clk);
    check("abort_no_done", 32'(done_a - d0), 32'd0);

    // rate_div=0 behaves as 1
    drive_a(1'b0, 8'h20, 8'd0);
    @(negedge clk);
    drive_a(1'b1, 8'h22, 8'd0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rate0_hold", 32'(a_if.duty_out), 32'h20);
    @(negedge clk);
    check("rate0_step1", 32'(a_if.duty_out), 32'h21);
    repeat (4) @(negedge clk);
    check("rate0_step2", 32'(a_if.duty_out), 32'h22);
    check("rate0_done", 32'(a_if.done), 32'd1);

    // asynchronous reset mid-ramp
    drive_a(1'b0, 8'h30, 8'd1);
    @(negedge clk);
    drive_a(1'b1, 8'h60, 8'd1);
    repeat (10) @(negedge clk);
    check("mrst_pre_duty", 32'(a_if.duty_out), 32'h32);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_duty", 32'(a_if.duty_out), 32'h00);
    check("mrst_busy", 32'(a_if.busy), 32'd0);
    check("mrst_done", 32'(a_if.done), 32'd0);
    check("mrst_state", 32'(a_if.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_reentry", 32'(a_if.state), 32'(UP));
    check("mrst_reentry_duty", 32'(a_if.duty_out), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Sits between the SPI register file and the PWM peripheral.
- Takes the SPI-written target duty cycle and slews the duty actually fed to pwm_peripheral toward it in fixed steps at a programmable rate, giving soft-start/fade on all PWM outputs.
- When ramping is disabled it passes the target through with one cycle of latency.

Parameters:
- PRESCALE, 1000, clk cycles per base tick (minimum 1).
- STEP, 1, duty LSBs moved per step event (1..255).
- RATE_W, 8, width of rate_div.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- ramp_en  input  1  1 = slew toward target; 0 = bypass
- target_duty  input  8  duty written over SPI (0x00..0xFF)
- rate_div  input  RATE_W  base ticks per step event; 0 is treated as 1
- duty_out  output  8  duty fed to pwm_peripheral pwm_duty_cycle
- busy  output  1  high while duty_out != target in ramp mode
- done  output  1  one-cycle pulse when a ramp reaches target

Behaviour:
- Reset (async assert, sync release): duty_out=0x00, busy=0, done=0, state=IDLE, prescaler=0, rate counter=0.
- States: IDLE, UP, DOWN. All outputs are registered.
- Bypass (ramp_en=0):
  - duty_out <= target_duty every cycle; state forced to IDLE.
  - Counters are cleared; busy=0, done=0.
- IDLE, ramp_en=1:
  - target>duty_out -> UP; target<duty_out -> DOWN.
  - busy goes 1 on the same edge as the state change.
- Prescaler: counts 0..PRESCALE-1 only in UP/DOWN. Tick when count==PRESCALE-1, then it wraps to 0.
- Rate counter: counts ticks. A step event fires on the tick that makes count==max(rate_div,1)-1, then the counter resets. rate_div is sampled live.
- Step arithmetic is done in 9 bits, with saturation and no wrap:
  - UP: duty_out <= min(duty_out+STEP, target).
  - DOWN: duty_out <= max(duty_out-STEP, target).
- Completion: on the step event that makes duty_out==target:
  - state -> IDLE and busy -> 0 on that edge;
  - done=1 for exactly the next cycle.
- Target change mid-ramp:
  - Direction is re-evaluated on every step event against the current target, so there is no overshoot.
  - If the target crosses duty_out, the direction flips at that step event.
  - If target==duty_out at any cycle in UP/DOWN: go to IDLE next edge and pulse done. Counters clear.
- ramp_en falls mid-ramp: next edge duty_out=target, IDLE, busy=0, no done pulse.
- Steady state: the prescaler does not run in IDLE. Counters restart from 0 on every entry to UP/DOWN.
- Latency:
  - first step event is PRESCALE*max(rate_div,1) cycles after entering UP/DOWN;
  - full ramp of N LSBs takes ceil(N/STEP) step events.
- Reset mid-ramp: immediate return to the reset values. Ramp state is not retained.

Decomposition:
- Shared package pwm_pkg:
  - state enum ramp_state_t {IDLE, UP, DOWN};
  - DUTY_W=8;
  - default PRESCALE constant.
- One natural sub-module, tick_prescaler:
  - parameter PRESCALE;
  - inputs clk, rst_n, run;
  - output tick;
  - clears its count when run=0.
- The rate counter and FSM stay in pwm_duty_ramp.
- Top level: SPI pwm_duty_cycle -> target_duty, register bit chosen by the top -> ramp_en, duty_out -> pwm_peripheral.

Test Plan (PRESCALE=4, STEP=1 unless noted):
- Reset: rst_n=0 asserted mid-cycle -> duty_out=0, busy=0, done=0 immediately, without waiting for a clk edge.
- Bypass: ramp_en=0, target 0x00->0xA5 -> duty_out=0xA5 one cycle later; busy never 1.
- Ramp up: ramp_en=1, rate_div=2, target 0x00->0x05:
  - duty_out increments every 8 cycles, reaching 0x05 after 40 cycles;
  - done pulses once; busy falls on the same edge.
- Saturation: STEP=16, duty_out=0xF8, target=0xFF -> single step to 0xFF, no wrap. DOWN from 0x08 with target 0x00 -> 0x00.
- Mid-ramp reversal: ramping up 0x10->0x40, target changed to 0x12 when duty_out=0x15 -> next step gives 0x14, then 0x13, then 0x12, then done. Never above 0x15.
- Abort: ramp_en dropped mid-ramp at duty_out 0x20, target 0x80 -> duty_out=0x80 next cycle, busy=0, no done pulse; rate_div=0 behaves as 1.
